// File: rtl/mem_port_arbiter_if.sv
// Bundle of CPU, auxiliary and memory-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              CpuReq;
    logic              CpuWE;
    logic [ADDR_W-1:0] CpuAddr;
    logic [DATA_W-1:0] CpuWData;
    logic              CpuAck;
    logic [DATA_W-1:0] CpuRData;

    logic              AuxReq;
    logic              AuxWE;
    logic [ADDR_W-1:0] AuxAddr;
    logic [DATA_W-1:0] AuxWData;
    logic              AuxAck;
    logic [DATA_W-1:0] AuxRData;

    logic              MemEn;
    logic              MemWE;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    logic              Busy;
    logic              GrantAux;

    modport slave (
        input  CpuReq, CpuWE, CpuAddr, CpuWData,
        output CpuAck, CpuRData,
        input  AuxReq, AuxWE, AuxAddr, AuxWData,
        output AuxAck, AuxRData,
        output MemEn, MemWE, MemAddr, MemWData,
        input  MemRData,
        output Busy, GrantAux
    );

    modport master (
        output CpuReq, CpuWE, CpuAddr, CpuWData,
        input  CpuAck, CpuRData,
        output AuxReq, AuxWE, AuxAddr, AuxWData,
        input  AuxAck, AuxRData,
        input  MemEn, MemWE, MemAddr, MemWData,
        output MemRData,
        input  Busy, GrantAux
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the CPU and an auxiliary requester, one transaction at a time.
// Ties alternate round-robin; define ARB_CPU_PRIORITY_EN to make the CPU win every tie instead.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1
) (
    input logic Clock,
    input logic Reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t            state, nextState;
    logic [1:0]        count, nextCount;
    logic              lastGrant, nextLastGrant;
    logic              grantAux, nextGrantAux;
    logic              opWrite, nextOpWrite;
    logic              memEn, nextMemEn;
    logic              memWE, nextMemWE;
    logic [ADDR_W-1:0] memAddr, nextMemAddr;
    logic [DATA_W-1:0] memWData, nextMemWData;
    logic [DATA_W-1:0] cpuRData, nextCpuRData;
    logic [DATA_W-1:0] auxRData, nextAuxRData;
    logic              cpuAck, nextCpuAck;
    logic              auxAck, nextAuxAck;
    logic              busy;
    logic              pickAux;

`ifdef ARB_CPU_PRIORITY_EN
    assign pickAux = bus.AuxReq && !bus.CpuReq;
`else
    assign pickAux = bus.AuxReq && (!bus.CpuReq || !lastGrant);
`endif

    // Every output comes straight from a register; lastGrant starts as aux so the CPU wins the first tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            count     <= '0;
            lastGrant <= 1'b1;
            grantAux  <= 1'b0;
            opWrite   <= 1'b0;
            memEn     <= 1'b0;
            memWE     <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            cpuRData  <= '0;
            auxRData  <= '0;
            cpuAck    <= 1'b0;
            auxAck    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nextState;
            count     <= nextCount;
            lastGrant <= nextLastGrant;
            grantAux  <= nextGrantAux;
            opWrite   <= nextOpWrite;
            memEn     <= nextMemEn;
            memWE     <= nextMemWE;
            memAddr   <= nextMemAddr;
            memWData  <= nextMemWData;
            cpuRData  <= nextCpuRData;
            auxRData  <= nextAuxRData;
            cpuAck    <= nextCpuAck;
            auxAck    <= nextAuxAck;
            busy      <= (nextState != IDLE);
        end
    end

    // Next-state logic also computes the next value of each output register.
    always_comb begin
        nextState     = state;
        nextCount     = count;
        nextLastGrant = lastGrant;
        nextGrantAux  = grantAux;
        nextOpWrite   = opWrite;
        nextMemEn     = 1'b0;
        nextMemWE     = 1'b0;
        nextMemAddr   = memAddr;
        nextMemWData  = memWData;
        nextCpuRData  = cpuRData;
        nextAuxRData  = auxRData;
        nextCpuAck    = 1'b0;
        nextAuxAck    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.CpuReq || bus.AuxReq) begin
                    nextState     = ISSUE;
                    nextGrantAux  = pickAux;
                    nextLastGrant = pickAux;
                    nextOpWrite   = pickAux ? bus.AuxWE    : bus.CpuWE;
                    nextMemAddr   = pickAux ? bus.AuxAddr  : bus.CpuAddr;
                    nextMemWData  = pickAux ? bus.AuxWData : bus.CpuWData;
                    nextMemEn     = 1'b1;
                    nextMemWE     = nextOpWrite;
                end
            end
            ISSUE: begin
                if (opWrite) begin
                    nextState  = ACK;
                    nextCpuAck = !grantAux;
                    nextAuxAck = grantAux;
                end else begin
                    nextState = WAIT;
                    nextCount = LAT_LOAD;
                end
            end
            WAIT: begin
                // The capture edge is the one where MemRData first holds the data for this read.
                if (count == 2'd0) begin
                    nextState  = ACK;
                    nextCpuAck = !grantAux;
                    nextAuxAck = grantAux;
                    if (grantAux) begin
                        nextAuxRData = bus.MemRData;
                    end else begin
                        nextCpuRData = bus.MemRData;
                    end
                end else begin
                    nextCount = count - 2'd1;
                end
            end
            ACK: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign bus.MemEn    = memEn;
    assign bus.MemWE    = memWE;
    assign bus.MemAddr  = memAddr;
    assign bus.MemWData = memWData;
    assign bus.CpuAck   = cpuAck;
    assign bus.AuxAck   = auxAck;
    assign bus.CpuRData = cpuRData;
    assign bus.AuxRData = auxRData;
    assign bus.Busy     = busy;
    assign bus.GrantAux = grantAux;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus random two-port traffic,
// compared every cycle against a transaction-level model that predicts issue/ack cycles.
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 16;
    localparam int READ_LAT = 3;

`ifdef ARB_CPU_PRIORITY_EN
    localparam logic [3:0] TIE_ORDER = 4'b0000;
`else
    localparam logic [3:0] TIE_ORDER = 4'b1010;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic initMem = 1'b1;
    bit   checkEn = 1'b0;
    int   checkCount = 0;
    int   failCount = 0;

    always #5 Clock = ~Clock;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    // Block RAM stand-in: reads appear READ_LAT edges after MemEn; junk otherwise.
    logic [DATA_W-1:0] memArr [0:255];
    logic [DATA_W-1:0] rdPipe [0:READ_LAT-1];

    always @(posedge Clock) begin
        if (initMem) begin
            for (int i = 0; i < 256; i++) memArr[i] <= 16'hA000 + 16'(i);
        end else if (bus.MemEn && bus.MemWE) begin
            memArr[bus.MemAddr[7:0]] <= bus.MemWData;
        end
        rdPipe[0] <= (bus.MemEn && !bus.MemWE) ? memArr[bus.MemAddr[7:0]] : 16'($urandom);
        for (int i = 1; i < READ_LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end

    assign bus.MemRData = rdPipe[READ_LAT-1];

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: transaction level, tracks which cycles the current grant issues and acks.
    int          cyc = 0;
    int          freeAt = 0;
    int          issueAt = 0;
    int          ackAt = 0;
    bit          txValid = 1'b0;
    bit          txAux = 1'b0;
    bit          txWE = 1'b0;
    bit          lastGrantM = 1'b1;
    logic [15:0] txRData = 16'h0;
    logic [15:0] modelMem [0:255];
    logic        expGrantAux = 1'b0;
    logic [15:0] expMemAddr = 16'h0;
    logic [15:0] expMemWData = 16'h0;
    logic [15:0] expCpuRData = 16'h0;
    logic [15:0] expAuxRData = 16'h0;

    initial begin
        logic [15:0] a;
        for (int i = 0; i < 256; i++) modelMem[i] = 16'hA000 + 16'(i);
        forever begin
            @(posedge Clock);
            if (Reset) begin
                txValid     = 1'b0;
                freeAt      = cyc + 1;
                lastGrantM  = 1'b1;
                expGrantAux = 1'b0;
                expMemAddr  = 16'h0;
                expMemWData = 16'h0;
                expCpuRData = 16'h0;
                expAuxRData = 16'h0;
            end else if (cyc >= freeAt && (bus.CpuReq || bus.AuxReq)) begin
`ifdef ARB_CPU_PRIORITY_EN
                txAux = !bus.CpuReq;
`else
                txAux = (bus.CpuReq && bus.AuxReq) ? !lastGrantM : bus.AuxReq;
`endif
                lastGrantM  = txAux;
                expGrantAux = txAux;
                txWE        = txAux ? bus.AuxWE : bus.CpuWE;
                a           = txAux ? bus.AuxAddr : bus.CpuAddr;
                expMemAddr  = a;
                expMemWData = txAux ? bus.AuxWData : bus.CpuWData;
                issueAt     = cyc + 1;
                ackAt       = txWE ? cyc + 2 : cyc + 2 + READ_LAT;
                freeAt      = ackAt + 1;
                txValid     = 1'b1;
                if (txWE) modelMem[a[7:0]] = expMemWData;
                else      txRData = modelMem[a[7:0]];
            end
            cyc = cyc + 1;
            if (txValid && !txWE && cyc == ackAt) begin
                if (txAux) expAuxRData = txRData;
                else       expCpuRData = txRData;
            end
        end
    end

    // Compare process: every output, every cycle, sampled mid-cycle.
    initial begin
        bit issueNow, ackNow, inTx;
        forever begin
            @(negedge Clock);
            if (checkEn) begin
                issueNow = txValid && (cyc == issueAt);
                ackNow   = txValid && (cyc == ackAt);
                inTx     = txValid && (cyc >= issueAt) && (cyc <= ackAt);
                checkOutput("MemEn",    16'(bus.MemEn),    16'(issueNow));
                checkOutput("MemWE",    16'(bus.MemWE),    16'(issueNow && txWE));
                checkOutput("MemAddr",  bus.MemAddr,       expMemAddr);
                checkOutput("MemWData", bus.MemWData,      expMemWData);
                checkOutput("CpuAck",   16'(bus.CpuAck),   16'(ackNow && !txAux));
                checkOutput("AuxAck",   16'(bus.AuxAck),   16'(ackNow && txAux));
                checkOutput("CpuRData", bus.CpuRData,      expCpuRData);
                checkOutput("AuxRData", bus.AuxRData,      expAuxRData);
                checkOutput("Busy",     16'(bus.Busy),     16'(inTx));
                checkOutput("GrantAux", 16'(bus.GrantAux), 16'(expGrantAux));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One complete transaction on one port, starting from an IDLE cycle, with literal expectations.
    task automatic runPort(input string name, input bit isAux, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input bit swap, input int expLat, input logic [15:0] expRData);
        int          lat = -1;
        int          enCount = 0;
        bit          otherAck = 1'b0;
        logic [15:0] rd = 16'h0;
        @(negedge Clock);
        if (isAux) begin
            bus.AuxReq = 1'b1; bus.AuxWE = we; bus.AuxAddr = addr; bus.AuxWData = wdata;
        end else begin
            bus.CpuReq = 1'b1; bus.CpuWE = we; bus.CpuAddr = addr; bus.CpuWData = wdata;
        end
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge Clock);
            if (bus.MemEn) enCount++;
            if (i == 1) begin
                checkOutput({name, " MemEn"},    16'(bus.MemEn), 16'd1);
                checkOutput({name, " MemWE"},    16'(bus.MemWE), 16'(we));
                checkOutput({name, " MemAddr"},  bus.MemAddr, addr);
                checkOutput({name, " MemWData"}, bus.MemWData, wdata);
                if (swap) begin
                    if (isAux) begin bus.AuxAddr = addr + 16'h0010; bus.AuxWData = ~wdata; end
                    else       begin bus.CpuAddr = addr + 16'h0010; bus.CpuWData = ~wdata; end
                end
            end
            if (isAux ? bus.CpuAck : bus.AuxAck) otherAck = 1'b1;
            if (isAux ? bus.AuxAck : bus.CpuAck) begin
                lat = i;
                rd  = isAux ? bus.AuxRData : bus.CpuRData;
            end
        end
        bus.CpuReq = 1'b0;
        bus.AuxReq = 1'b0;
        checkOutput({name, " latency"},     16'(lat), 16'(expLat));
        checkOutput({name, " single MemEn"}, 16'(enCount), 16'd1);
        checkOutput({name, " other ack"},   16'(otherAck), 16'd0);
        if (!we) checkOutput({name, " rdata"}, rd, expRData);
    endtask

    task automatic applyReset;
        int          lat = -1;
        logic [15:0] rd = 16'h0;
        bus.CpuReq = 1'b1; bus.CpuWE = 1'b0; bus.CpuAddr = 16'h0005; bus.CpuWData = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            checkOutput("reset MemEn",   16'(bus.MemEn),  16'd0);
            checkOutput("reset Busy",    16'(bus.Busy),   16'd0);
            checkOutput("reset CpuAck",  16'(bus.CpuAck), 16'd0);
            checkOutput("reset MemAddr", bus.MemAddr,     16'h0000);
        end
        Reset   = 1'b0;
        initMem = 1'b0;
        @(negedge Clock);
        checkOutput("post-reset MemEn",   16'(bus.MemEn), 16'd1);
        checkOutput("post-reset MemAddr", bus.MemAddr,    16'h0005);
        for (int i = 2; i <= 20 && lat < 0; i++) begin
            @(negedge Clock);
            if (bus.CpuAck) begin lat = i; rd = bus.CpuRData; end
        end
        bus.CpuReq = 1'b0;
        checkOutput("post-reset read latency", 16'(lat), 16'd5);
        checkOutput("post-reset read data",    rd,       16'hA005);
    endtask

    task automatic applyTie;
        logic [3:0] order = 4'b0000;
        logic [3:0] expOrder = TIE_ORDER;
        int         got = 0;
        int         waited = 0;
        bit         sawAux = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        bus.CpuReq = 1'b1; bus.CpuWE = 1'b0; bus.CpuAddr = 16'h0001;
        bus.AuxReq = 1'b1; bus.AuxWE = 1'b0; bus.AuxAddr = 16'h0002;
        while (got < 4 && waited < 80) begin
            @(negedge Clock);
            waited++;
            if (bus.CpuAck)      begin order[got] = 1'b0; got++; end
            else if (bus.AuxAck) begin order[got] = 1'b1; got++; end
        end
        checkOutput("tie grant count", 16'(got), 16'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("tie grant %0d", i), 16'(order[i]), 16'(expOrder[i]));
        bus.CpuReq = 1'b0;
        for (int i = 0; i < 20 && !sawAux; i++) begin
            @(negedge Clock);
            if (bus.AuxAck) sawAux = 1'b1;
        end
        bus.AuxReq = 1'b0;
        checkOutput("aux after cpu drop", 16'(sawAux), 16'd1);
    endtask

    task automatic applyResetInWait;
        int strayAck = 0;
        @(negedge Clock);
        bus.AuxReq = 1'b1; bus.AuxWE = 1'b0; bus.AuxAddr = 16'h0021; bus.AuxWData = 16'h0;
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("wait Busy", 16'(bus.Busy), 16'd1);
        Reset      = 1'b1;
        bus.AuxReq = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        checkOutput("abort Busy",     16'(bus.Busy),     16'd0);
        checkOutput("abort MemEn",    16'(bus.MemEn),    16'd0);
        checkOutput("abort AuxAck",   16'(bus.AuxAck),   16'd0);
        checkOutput("abort AuxRData", bus.AuxRData,      16'h0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (bus.AuxAck) strayAck++;
        end
        checkOutput("abort stray AuxAck", 16'(strayAck), 16'd0);
    endtask

    // Random traffic on both ports with occasional resets; the compare process does the checking.
    task automatic applyStimulus(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge Clock);
            if (Reset) Reset = 1'b0;
            else if ($urandom_range(0, 199) == 0) Reset = 1'b1;

            if (bus.CpuReq && bus.CpuAck) bus.CpuReq = 1'b0;
            if (!bus.CpuReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.CpuReq   = 1'b1;
                    bus.CpuWE    = 1'($urandom_range(0, 1));
                    bus.CpuAddr  = 16'($urandom_range(0, 63));
                    bus.CpuWData = 16'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.CpuAddr  = 16'($urandom_range(0, 63));
                bus.CpuWData = 16'($urandom);
            end

            if (bus.AuxReq && bus.AuxAck) bus.AuxReq = 1'b0;
            if (!bus.AuxReq) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.AuxReq   = 1'b1;
                    bus.AuxWE    = 1'($urandom_range(0, 1));
                    bus.AuxAddr  = 16'($urandom_range(0, 63));
                    bus.AuxWData = 16'($urandom);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.AuxAddr  = 16'($urandom_range(0, 63));
                bus.AuxWData = 16'($urandom);
            end
        end
        bus.CpuReq = 1'b0;
        bus.AuxReq = 1'b0;
        Reset      = 1'b0;
    endtask

    initial begin
        bus.CpuReq = 1'b0; bus.CpuWE = 1'b0; bus.CpuAddr = '0; bus.CpuWData = '0;
        bus.AuxReq = 1'b0; bus.AuxWE = 1'b0; bus.AuxAddr = '0; bus.AuxWData = '0;
        @(negedge Clock);
        checkEn = 1'b1;

        applyReset();
        runPort("cpu write", 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 2, 16'h0000);
        runPort("cpu read",  1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 5, 16'hBEEF);
        applyTie();
        applyResetInWait();
        runPort("cpu read after abort", 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 5, 16'hBEEF);
        runPort("aux addr swap", 1'b1, 1'b0, 16'h0020, 16'h5555, 1'b1, 5, 16'hA020);
        @(negedge Clock);
        checkOutput("aux rdata hold", bus.AuxRData, 16'hA020);

        applyStimulus(3000);
        repeat (20) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between two requesters: the CPU (fetch, load, store) and an auxiliary port (I/O or display DMA).
- Each access runs as a request/acknowledge transaction. The arbiter grants one requester, issues one memory cycle, waits the memory read latency, then returns an acknowledge and the read data.
- Sits between CPU_Controller/datapath memory muxing and the block RAM.

Parameters:
- ADDR_W, 16, address width of both requesters and memory.
- DATA_W, 16, data width.
- READ_LAT, 1, cycles from MemEn to valid MemRData. Legal range 1..4; other values are unsupported.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- CpuReq  in  1  CPU access request; held until CpuAck.
- CpuWE  in  1  1 = write, 0 = read; stable while CpuReq is high.
- CpuAddr  in  ADDR_W  CPU address.
- CpuWData  in  DATA_W  CPU write data.
- CpuAck  out  1  one-cycle completion pulse.
- CpuRData  out  DATA_W  read data, valid when CpuAck=1.
- AuxReq, AuxWE, AuxAddr, AuxWData  in  1/1/ADDR_W/DATA_W  auxiliary port, same rules as the CPU port.
- AuxAck  out  1  one-cycle completion pulse.
- AuxRData  out  DATA_W  read data, valid when AuxAck=1.
- MemEn  out  1  memory access strobe.
- MemWE  out  1  memory write enable; high only together with MemEn.
- MemAddr  out  ADDR_W  memory address.
- MemWData  out  DATA_W  memory write data.
- MemRData  in  DATA_W  memory read data.
- Busy  out  1  high whenever state != IDLE.
- GrantAux  out  1  owner of the current or last transaction (1 = aux).

Behaviour:
- All outputs are registered.
- Reset (sampled at a rising edge):
  - state=IDLE; latency counter=0; last_grant=aux.
  - CpuAck=AuxAck=MemEn=MemWE=0.
  - MemAddr=MemWData=CpuRData=AuxRData=0.
  - Busy=0, GrantAux=0.
  - Reset mid-transaction aborts the transaction with no Ack. MemEn/MemWE are 0 in the cycle after the reset edge.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Requests are sampled in cycle t.
  - If no request, remain in IDLE.
  - If only one requester is active, grant it.
  - If both are active, round-robin: grant the requester that is not last_grant, then update last_grant. After reset, the CPU therefore wins the first tie.
  - The granted port's WE/Addr/WData are latched. Next state is ISSUE.
- ISSUE (cycle t+1):
  - MemEn=1, MemWE=latched WE, MemAddr/MemWData=latched values, for exactly one cycle.
  - Write: next state ACK.
  - Read: next state WAIT, counter loaded with READ_LAT-1.
- WAIT:
  - MemEn=0.
  - At each edge: if counter==0, capture MemRData into the granted port's RData and go to ACK; otherwise decrement the counter.
  - Data is therefore sampled from cycle t+1+READ_LAT.
- ACK:
  - The granted port's Ack=1 for exactly one cycle; the other port's Ack stays 0.
  - Next state is IDLE.
- Latency from request sampled to Ack:
  - Write: Ack in cycle t+2.
  - Read: Ack in cycle t+2+READ_LAT.
- Handshake rules:
  - A requester drops Req at the edge that ends its Ack cycle; otherwise it is re-arbitrated as a new request.
  - Req/WE/Addr/WData changes while Req is high and before Ack are ignored, because values were latched at grant.
  - The ungranted requester keeps Req high and is served next.
- RData registers hold their value until the next read completion for that port. Writes do not modify RData.
- Back-to-back: a continuously held request gets one transaction per 3 cycles (write) or 3+READ_LAT cycles (read). With both ports saturated, grants alternate CPU, aux, CPU, and so on.

Optional Feature:
- Macro: ARB_CPU_PRIORITY_EN.
- Defined: fixed priority.
  - The CPU always wins a tie; last_grant is ignored.
  - Aux is served only when CpuReq=0 in the IDLE sample cycle.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset: hold Reset=1 for 2 cycles with CpuReq=1 -> all outputs 0 and no MemEn. After release, the CPU read is issued on the 2nd cycle after release.
- CPU write, READ_LAT=1, CpuAddr=16'h0010, CpuWData=16'hBEEF -> MemEn=MemWE=1 with addr 0010 / data BEEF for one cycle; CpuAck at t+2; AuxAck stays 0.
- CPU read of address 0010, memory model returns BEEF, READ_LAT=3 -> MemEn for one cycle at t+1, MemWE=0; CpuAck with CpuRData=16'hBEEF at t+5.
- CpuReq and AuxReq asserted in the same cycle, both reads, held through 4 grants -> grant order CPU, aux, CPU, aux. With ARB_CPU_PRIORITY_EN defined -> aux is served only after CpuReq is dropped.
- Reset asserted during WAIT of an aux read -> no AuxAck; Busy=0 next cycle; a subsequent CPU read completes normally.
- Address/data changed mid-transaction: AuxAddr switches from 0020 to 0030 after grant -> MemAddr=0020 and AuxRData holds the data from address 0020.
